// File: rtl/allpass_pkg.sv
// Shared arithmetic helpers for the allpass cascade.
// ALLPASS_SAT_EN selects saturating sums; otherwise sums wrap.
package allpass_pkg;

  localparam int unsigned MAX_W = 32;
  typedef logic signed [2*MAX_W-1:0] wide_t;

  // Index width for n entries, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Q1.(w-1) product rescale; arithmetic shift floors toward -inf.
  function automatic wide_t scale_prod(input wide_t p, input int unsigned w);
    return p >>> (w - 1);
  endfunction

  // True when s does not fit in a signed w-bit word.
  function automatic logic sum_ovf(input wide_t s, input int unsigned w);
    wide_t hi, lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    return (s > hi) || (s < lo);
  endfunction

  // Bring a (w+1)-bit sum back to w bits: clamp or wrap.
  function automatic wide_t reduce_sum(input wide_t s, input int unsigned w);
`ifdef ALLPASS_SAT_EN
    wide_t hi, lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
`else
    return (s <<< (2*MAX_W - w)) >>> (2*MAX_W - w);
`endif
  endfunction

endpackage

// File: rtl/allpass_stage.sv
// One first-order allpass section with per-channel state.
// y = s + c*x ; s' = x - c*y ; y is registered and passed on.
module allpass_stage
  import allpass_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CH_W  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] coef_i,
  input  logic             valid_i,
  input  logic [CH_W-1:0]  ch_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ovf_i,
  output logic             valid_o,
  output logic [CH_W-1:0]  ch_o,
  output logic [WIDTH-1:0] data_o,
  output logic             ovf_o
);

  // Full power-of-two depth keeps the index exact; out-of-range
  // channels never reach a stage, so the spare entries stay at zero.
  localparam int DEPTH = 1 << CH_W;

  logic signed [WIDTH-1:0]   state_q [DEPTH];
  logic signed [WIDTH-1:0]   state_d;
  logic signed [WIDTH-1:0]   coef_s, x_s, s_s, cx, cy, data_d;
  logic signed [2*WIDTH-1:0] prod_cx, prod_cy;
  logic signed [WIDTH:0]     sum_y, sum_s;
  logic                      ovf_loc;
  logic                      valid_q, ovf_q;
  logic [CH_W-1:0]           ch_q;
  logic [WIDTH-1:0]          data_q;

  // Allpass arithmetic for the sample currently at this stage.
  always_comb begin
    coef_s  = signed'(coef_i);
    x_s     = signed'(data_i);
    s_s     = state_q[ch_i];
    prod_cx = (2*WIDTH)'(coef_s) * (2*WIDTH)'(x_s);
    cx      = WIDTH'(scale_prod(wide_t'(prod_cx), WIDTH));
    sum_y   = (WIDTH+1)'(s_s) + (WIDTH+1)'(cx);
    data_d  = WIDTH'(reduce_sum(wide_t'(sum_y), WIDTH));
    prod_cy = (2*WIDTH)'(coef_s) * (2*WIDTH)'(data_d);
    cy      = WIDTH'(scale_prod(wide_t'(prod_cy), WIDTH));
    sum_s   = (WIDTH+1)'(x_s) - (WIDTH+1)'(cy);
    state_d = WIDTH'(reduce_sum(wide_t'(sum_s), WIDTH));
`ifdef ALLPASS_SAT_EN
    ovf_loc = sum_ovf(wide_t'(sum_y), WIDTH) | sum_ovf(wide_t'(sum_s), WIDTH);
`else
    ovf_loc = 1'b0;
`endif
  end

  // State update for the owning channel plus the pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_i;
      ovf_q   <= valid_i & (ovf_i | ovf_loc);
      if (valid_i) begin
        state_q[ch_i] <= state_d;
        ch_q          <= ch_i;
        data_q        <= data_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign ch_o    = ch_q;
  assign data_o  = data_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/allpass_cascade.sv
// Time-multiplexed multi-channel cascade of first-order allpass stages.
// Build option ALLPASS_SAT_EN: saturating sums with ovf reporting.
module allpass_cascade
  import allpass_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int STAGES   = 4,
  parameter int CHANNELS = 2,
  localparam int CH_W    = idx_width(CHANNELS),
  localparam int AW      = idx_width(STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [WIDTH-1:0] in_data,
  input  logic             coef_we,
  input  logic [AW-1:0]    coef_addr,
  input  logic [WIDTH-1:0] coef_data,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic [WIDTH-1:0] out_data,
  output logic             ovf
);

  localparam int CDEPTH = 1 << AW;

  logic [WIDTH-1:0] coef_q  [CDEPTH];
  logic             valid_w [STAGES+1];
  logic [CH_W-1:0]  ch_w    [STAGES+1];
  logic [WIDTH-1:0] data_w  [STAGES+1];
  logic             ovf_w   [STAGES+1];

  // Coefficient register file; writes beyond the last stage are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CDEPTH; i++) coef_q[i] <= '0;
    end else if (coef_we && (32'(coef_addr) < STAGES)) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  assign valid_w[0] = in_valid && (32'(in_ch) < CHANNELS);
  assign ch_w[0]    = in_ch;
  assign data_w[0]  = in_data;
  assign ovf_w[0]   = 1'b0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    allpass_stage #(
      .WIDTH (WIDTH),
      .CH_W  (CH_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .coef_i  (coef_q[k]),
      .valid_i (valid_w[k]),
      .ch_i    (ch_w[k]),
      .data_i  (data_w[k]),
      .ovf_i   (ovf_w[k]),
      .valid_o (valid_w[k+1]),
      .ch_o    (ch_w[k+1]),
      .data_o  (data_w[k+1]),
      .ovf_o   (ovf_w[k+1])
    );
  end

  assign out_valid = valid_w[STAGES];
  assign out_ch    = ch_w[STAGES];
  assign out_data  = data_w[STAGES];
  assign ovf       = ovf_w[STAGES];

endmodule
